bcd_scan_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with a multiplexed 7-segment display driver. It replaces the single-digit derived-clock countdown. All logic runs on one clock, with a clock-enable tick prescaler and no generated clocks. It adds direction control, synchronous load, a wrap flag and time-multiplexed digit scanning. It sits between board switches/buttons and the segment/anode pins.

---
 rtl/bcd_scan_counter_pkg.sv | 24 ++
 rtl/bcd_scan_counter_seg7_decode.sv | 26 ++
 rtl/bcd_scan_counter.sv | 162 ++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_counter_pkg.sv
// Shared types and active-low 7-segment glyphs for the BCD scan counter.
// Segment order is {a,b,c,d,e,f,g,dp}, with bit 7 = a.
package bcd_scan_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_0     = 8'b00000011;
    localparam logic [7:0] SEG_1     = 8'b10011111;
    localparam logic [7:0] SEG_2     = 8'b00100101;
    localparam logic [7:0] SEG_3     = 8'b00001101;
    localparam logic [7:0] SEG_4     = 8'b10011001;
    localparam logic [7:0] SEG_5     = 8'b01001001;
    localparam logic [7:0] SEG_6     = 8'b11000001;
    localparam logic [7:0] SEG_7     = 8'b00011011;
    localparam logic [7:0] SEG_8     = 8'b00000001;
    localparam logic [7:0] SEG_9     = 8'b00001001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Out-of-range nibbles become 0 so the counter never holds a non-BCD digit.
    function automatic bcd_t sanitize(input bcd_t d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD input shows blank.
module seg7_decode
    import bcd_scan_counter_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a tick prescaler and multiplexed 7-segment scan.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       r_presc;
    logic [4*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic [SW-1:0]       r_scanDiv;
    logic [IW-1:0]       r_scanIdx;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic                w_tick;
    logic                w_scanAdv;
    logic [4*DIGITS-1:0] w_stepVal;
    logic [4*DIGITS-1:0] w_loadVal;
    logic                w_carry;
    logic [DIGITS-1:0]   w_lzMask;
    bcd_t                w_nibble;
    logic                w_digitBlank;
    logic [7:0]          w_decSeg;

    assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
    assign w_scanAdv = (r_scanDiv == SW'(SCAN_DIV - 1));

    // A load restarts the prescaler so the next step lands a full period later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_presc <= '0;
        else if (load || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
    always_comb begin
        w_stepVal = r_count;
        w_carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (up) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_stepVal[4*i +: 4] = 4'd0;
                    end else begin
                        w_stepVal[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_stepVal[4*i +: 4] = 4'd9;
                    end else begin
                        w_stepVal[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_loadVal = '0;
        for (int i = 0; i < DIGITS; i++)
            w_loadVal[4*i +: 4] = sanitize(load_val[4*i +: 4]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (load) begin
                r_count <= w_loadVal;
            end else if (w_tick && en) begin
                r_count <= w_stepVal;
                r_wrap  <= w_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scanDiv <= '0;
            r_scanIdx <= '0;
        end else if (w_scanAdv) begin
            r_scanDiv <= '0;
            r_scanIdx <= (r_scanIdx == IW'(DIGITS - 1)) ? '0 : r_scanIdx + 1'b1;
        end else begin
            r_scanDiv <= r_scanDiv + 1'b1;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic w_zeroRun;

    // Walk down from the top digit; blanking stops at the first non-zero digit.
    always_comb begin
        w_lzMask  = '0;
        w_zeroRun = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zeroRun   = w_zeroRun & (r_count[4*i +: 4] == 4'd0);
            w_lzMask[i] = w_zeroRun;
        end
    end
`else
    assign w_lzMask = '0;
`endif

    always_comb begin
        w_nibble     = '0;
        w_digitBlank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scanIdx == IW'(i)) begin
                w_nibble     = r_count[4*i +: 4];
                w_digitBlank = w_lzMask[i];
            end
        end
    end

    seg7_decode u_decode (
        .i_bcd (w_nibble),
        .o_seg (w_decSeg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_digitBlank ? SEG_BLANK : w_decSeg;
            r_an  <= ~(DIGITS'(1) << r_scanIdx);
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed testbench for bcd_scan_counter with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
// Build with LEAD_ZERO_BLANK_EN defined to exercise leading-zero blanking.
module tb_bcd_scan_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic       wrap;
    logic [7:0] seg;
    logic [1:0] an;

    int passCount = 0;
    int checkCount = 0;
    int cyc = 0;

    bcd_scan_counter #(
        .DIGITS   (2),
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Posedges since reset release: sets the expected scan position.
    always @(posedge clk or negedge reset) begin
        if (!reset)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0:       return 8'b00000011;
            1:       return 8'b10011111;
            2:       return 8'b00100101;
            3:       return 8'b00001101;
            4:       return 8'b10011001;
            5:       return 8'b01001001;
            6:       return 8'b11000001;
            7:       return 8'b00011011;
            8:       return 8'b00000001;
            9:       return 8'b00001001;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] bcdOf(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int scanIdx(input int n);
        return ((n - 1) / 2) % 2;
    endfunction

    task automatic doLoad(input logic [7:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (count !== 8'h00) $display("[TB] FAIL resetCount: got %h want 00", count); else passCount++;
        checkCount++;
        if (wrap !== 1'b0) $display("[TB] FAIL resetWrap: got %b want 0", wrap); else passCount++;
        checkCount++;
        if (seg !== 8'hFF) $display("[TB] FAIL resetSeg: got %b want 11111111", seg); else passCount++;
        checkCount++;
        if (an !== 2'b11) $display("[TB] FAIL resetAn: got %b want 11", an); else passCount++;
        reset = 1'b1;
        @(negedge clk);
        checkCount++;
        if (an !== 2'b10) $display("[TB] FAIL firstScanAn: got %b want 10", an); else passCount++;
        checkCount++;
        if (seg !== 8'b00000011) $display("[TB] FAIL firstScanSeg: got %b want 00000011", seg); else passCount++;
        checkCount++;
        if (count !== 8'h00) $display("[TB] FAIL postResetCount: got %h want 00", count); else passCount++;
    endtask

    task automatic test_up_count;
        int val;
        logic wrapExp;
        en = 1'b1;
        up = 1'b1;
        doLoad(8'h00);
        val = 0;
        for (int k = 1; k <= 100; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                wrapExp = 1'b0;
                if (c == 3) begin
                    wrapExp = (val == 99);
                    val = (val + 1) % 100;
                end
                checkCount++;
                if (count !== bcdOf(val))
                    $display("[TB] FAIL upCount step %0d: got %h want %h", k, count, bcdOf(val));
                else passCount++;
                checkCount++;
                if (wrap !== wrapExp)
                    $display("[TB] FAIL upWrap step %0d: got %b want %b", k, wrap, wrapExp);
                else passCount++;
            end
        end
    endtask

    task automatic test_down_count;
        int val;
        logic wrapExp;
        en = 1'b1;
        up = 1'b0;
        doLoad(8'h10);
        val = 10;
        for (int k = 1; k <= 11; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                wrapExp = 1'b0;
                if (c == 3) begin
                    wrapExp = (val == 0);
                    val = (val + 99) % 100;
                end
                checkCount++;
                if (count !== bcdOf(val))
                    $display("[TB] FAIL downCount step %0d: got %h want %h", k, count, bcdOf(val));
                else passCount++;
                checkCount++;
                if (wrap !== wrapExp)
                    $display("[TB] FAIL downWrap step %0d: got %b want %b", k, wrap, wrapExp);
                else passCount++;
            end
        end
        checkCount++;
        if (count !== 8'h99) $display("[TB] FAIL downFinal: got %h want 99", count); else passCount++;
    endtask

    task automatic test_load_vs_tick;
        en = 1'b1;
        up = 1'b1;
        doLoad(8'h00);
        repeat (3) @(negedge clk);
        checkCount++;
        if (count !== 8'h00) $display("[TB] FAIL preTickCount: got %h want 00", count); else passCount++;
        load = 1'b1;
        load_val = 8'h3F;
        @(negedge clk);
        load = 1'b0;
        checkCount++;
        if (count !== 8'h30) $display("[TB] FAIL loadWinsCount: got %h want 30", count); else passCount++;
        checkCount++;
        if (wrap !== 1'b0) $display("[TB] FAIL loadWinsWrap: got %b want 0", wrap); else passCount++;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkCount++;
            if (count !== ((c == 4) ? 8'h31 : 8'h30))
                $display("[TB] FAIL loadRestart cycle %0d: got %h want %h", c, count, (c == 4) ? 8'h31 : 8'h30);
            else passCount++;
        end
        en = 1'b0;
        doLoad(8'hA7);
        checkCount++;
        if (count !== 8'h07) $display("[TB] FAIL loadSanitize: got %h want 07", count); else passCount++;
    endtask

    task automatic test_hold;
        logic [1:0] anExp;
        logic [7:0] segExp;
        en = 1'b0;
        up = 1'b1;
        doLoad(8'h47);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            anExp  = (scanIdx(cyc) == 0) ? 2'b10 : 2'b01;
            segExp = (scanIdx(cyc) == 0) ? glyph(7) : glyph(4);
            checkCount++;
            if (count !== 8'h47) $display("[TB] FAIL holdCount cycle %0d: got %h want 47", c, count); else passCount++;
            checkCount++;
            if (wrap !== 1'b0) $display("[TB] FAIL holdWrap cycle %0d: got %b want 0", c, wrap); else passCount++;
            checkCount++;
            if (an !== anExp) $display("[TB] FAIL holdAn cycle %0d: got %b want %b", c, an, anExp); else passCount++;
            checkCount++;
            if (seg !== segExp) $display("[TB] FAIL holdSeg cycle %0d: got %b want %b", c, seg, segExp); else passCount++;
        end
    endtask

    task automatic checkDisplay(input logic [7:0] v, input logic [7:0] seg1Exp, input logic [7:0] seg0Exp);
        logic [7:0] segExp;
        en = 1'b0;
        doLoad(v);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            segExp = (scanIdx(cyc) == 0) ? seg0Exp : seg1Exp;
            checkCount++;
            if (seg !== segExp)
                $display("[TB] FAIL leadZero value %h cycle %0d: got %b want %b", v, c, seg, segExp);
            else passCount++;
        end
    endtask

    task automatic test_lead_zero;
`ifdef LEAD_ZERO_BLANK_EN
        checkDisplay(8'h05, 8'hFF, glyph(5));
        checkDisplay(8'h00, 8'hFF, glyph(0));
`else
        checkDisplay(8'h05, glyph(0), glyph(5));
        checkDisplay(8'h00, glyph(0), glyph(0));
`endif
        checkDisplay(8'h50, glyph(5), glyph(0));
    endtask

    task automatic test_reset_mid;
        en = 1'b1;
        up = 1'b1;
        doLoad(8'h37);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkCount++;
        if (count !== 8'h00) $display("[TB] FAIL midResetCount: got %h want 00", count); else passCount++;
        checkCount++;
        if (seg !== 8'hFF) $display("[TB] FAIL midResetSeg: got %b want 11111111", seg); else passCount++;
        checkCount++;
        if (an !== 2'b11) $display("[TB] FAIL midResetAn: got %b want 11", an); else passCount++;
        checkCount++;
        if (wrap !== 1'b0) $display("[TB] FAIL midResetWrap: got %b want 0", wrap); else passCount++;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkCount++;
            if (count !== ((c == 4) ? 8'h01 : 8'h00))
                $display("[TB] FAIL postResetStep cycle %0d: got %h want %h", c, count, (c == 4) ? 8'h01 : 8'h00);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_load_vs_tick();
        test_hold();
        test_lead_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
